ram_fill_arbiter: RTL and testbench

- Responder side of the req/grant load handshake used by the systolic-array controller's input and weight channels.
- Arbitrates NREQ requesters round-robin and holds the grant for exactly one BURST-beat transfer.
- During each beat, muxes the owner's address and data onto the shared RAM write port, registered.
- Sits between the controller's load requesters and the shared input/weight RAM.

---
 rtl/ram_fill_arbiter_pkg.sv | 10 +
 rtl/ram_fill_arbiter_if.sv | 19 +
 rtl/ram_fill_arbiter_rr_pick.sv | 19 +
 rtl/ram_fill_arbiter.sv | 74 +++++++
 tb/tb_ram_fill_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_fill_arbiter_pkg.sv
// ram_fill_arbiter_pkg: FSM state encoding and width helper shared by the arbiter files.
package ram_fill_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, XFER = 2'd2, GAP = 2'd3} state_t;
  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) begin
    end
    return r;
  endfunction
endpackage

// File: rtl/ram_fill_arbiter_if.sv
// ram_fill_arbiter_if: requester load handshake plus the shared RAM write port.
interface ram_fill_arbiter_if #(
  parameter int ADD_WIDTH  = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 2
);
  logic [NREQ-1:0]                 req;
  logic [NREQ-1:0]                 grant;
  logic [NREQ*(ADD_WIDTH+1)-1:0]   addr_in;
  logic [NREQ*DATA_WIDTH-1:0]      data_in;
  logic                            ram_we;
  logic [ADD_WIDTH:0]              ram_addr;
  logic [DATA_WIDTH-1:0]           ram_din;
  logic                            busy;
  logic [NREQ-1:0]                 done;
  logic                            err;
  modport master (output req, addr_in, data_in, input grant, ram_we, ram_addr, ram_din, busy, done, err);
  modport slave  (input req, addr_in, data_in, output grant, ram_we, ram_addr, ram_din, busy, done, err);
endinterface

// File: rtl/ram_fill_arbiter_rr_pick.sv
// ram_fill_arbiter_rr_pick: picks the first set request at or after ptr, wrapping, as one-hot.
module ram_fill_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);
  always_comb begin
    pick = '0;
    // Walk from farthest to nearest so the nearest set bit overwrites the rest
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) pick = NREQ'(1) << ((int'(ptr) + k) % NREQ);
    end
    valid = |req;
  end
endmodule

// File: rtl/ram_fill_arbiter.sv
// ram_fill_arbiter: round-robin grant of fixed-length write bursts from NREQ
// requesters onto one shared RAM write port, with sticky done/err reporting.
module ram_fill_arbiter
  import ram_fill_arbiter_pkg::*;
#(
  parameter int ADD_WIDTH  = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NREQ       = 2,
  parameter int BURST      = 16
) (
  input logic clk,
  input logic rst,
  ram_fill_arbiter_if.slave bus
);
  localparam int AW = ADD_WIDTH + 1;
  localparam int PW = NREQ > 1 ? clog2(NREQ) : 1;
  localparam int CW = BURST > 1 ? clog2(BURST) : 1;
  state_t state, state_n;
  logic [PW-1:0] owner, ptr, pick_idx, owner_nx;
  logic [CW-1:0] cnt;
  logic [NREQ-1:0] pick;
  logic valid, beat, drop, last;
  ram_fill_arbiter_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(bus.req), .ptr(ptr), .pick(pick), .valid(valid)
  );
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) if (pick[i]) pick_idx = PW'(i);
  end
  always_comb begin
    beat = state == XFER && bus.req[owner];
    drop = state == XFER && !bus.req[owner];
    last = beat && cnt == CW'(BURST - 1);
    owner_nx = owner == PW'(NREQ - 1) ? '0 : owner + 1'b1;
    state_n = state == IDLE ? (valid ? GRANT : IDLE) :
              state == GRANT ? XFER :
              state == XFER ? (last || drop ? GAP : XFER) : IDLE;
  end
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner        <= '0;
      ptr          <= '0;
      cnt          <= '0;
      bus.grant    <= '0;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      bus.done     <= '0;
      bus.err      <= 1'b0;
    end else begin
      state      <= state_n;
      bus.ram_we <= beat;
      if (state == IDLE && valid) begin
        owner     <= pick_idx;
        bus.grant <= pick;
        cnt       <= '0;
      end
      if (beat) begin
        bus.ram_addr <= bus.addr_in[int'(owner) * AW +: AW];
        bus.ram_din  <= bus.data_in[int'(owner) * DATA_WIDTH +: DATA_WIDTH];
        cnt          <= cnt + 1'b1;
      end
      // Completion and early drop both release the channel and rotate priority
      if (last || drop) begin
        bus.grant <= '0;
        ptr       <= owner_nx;
      end
      if (last) bus.done[owner] <= 1'b1;
      if (drop) bus.err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_fill_arbiter.sv
// tb_ram_fill_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_ram_fill_arbiter;
  localparam int ADD_WIDTH = 6, DATA_WIDTH = 8, NREQ = 2, BURST = 16, AW = ADD_WIDTH + 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ram_fill_arbiter_if #(.ADD_WIDTH(ADD_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NREQ(NREQ)) bus ();
  ram_fill_arbiter #(.ADD_WIDTH(ADD_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NREQ(NREQ), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int n_cmp = 0, n_bad = 0;
  int m_own, m_beats, m_ptr;
  bit m_first, m_gap, m_err, m_we;
  logic [NREQ-1:0] m_done;
  logic [AW-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_din;
  int gcnt[NREQ], bursts[NREQ], drop_at[NREQ], base[NREQ];
  bit rnd[NREQ], noise[NREQ];
  int wr_cnt, wr_hi, g0_cycles, g1_cycles;
  logic [NREQ-1:0] prev_grant;
  logic [NREQ-1:0] order[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic release_owner();
    m_ptr = (m_own + 1) % NREQ;
    m_own = -1;
    m_gap = 1;
  endtask
  task automatic model_step();
    bit nwe;
    nwe = 0;
    if (m_gap) m_gap = 0;
    else if (m_own < 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (bus.req[c] && m_own < 0) begin
          m_own = c;
          m_first = 1;
          m_beats = 0;
        end
      end
    end else if (m_first) m_first = 0;
    else if (bus.req[m_own]) begin
      nwe = 1;
      m_addr = bus.addr_in[m_own*AW +: AW];
      m_din = bus.data_in[m_own*DATA_WIDTH +: DATA_WIDTH];
      m_beats++;
      if (m_beats == BURST) begin
        m_done[m_own] = 1'b1;
        release_owner();
      end
    end else begin
      m_err = 1;
      release_owner();
    end
    m_we = nwe;
  endtask
  task automatic compare_all();
    check("grant", bus.grant, m_own < 0 ? 0 : (1 << m_own));
    check("busy", bus.busy, m_own >= 0 || m_gap);
    check("ram_we", bus.ram_we, m_we);
    check("ram_addr", bus.ram_addr, m_addr);
    check("ram_din", bus.ram_din, m_din);
    check("done", bus.done, m_done);
    check("err", bus.err, m_err);
    if (bus.ram_we) begin
      wr_cnt++;
      if (bus.ram_addr >= 16) wr_hi++;
    end
    if (bus.grant != 0 && prev_grant == 0) order.push_back(bus.grant);
    if (bus.grant == 2'b01) g0_cycles++;
    if (bus.grant[1]) g1_cycles++;
    prev_grant = bus.grant;
  endtask
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      logic r;
      logic [AW-1:0] a;
      if (bus.grant[i]) begin
        gcnt[i]++;
        if (gcnt[i] == 1 && rnd[i]) drop_at[i] = ($urandom % 4 == 0) ? int'($urandom % BURST) : -1;
        r = !(drop_at[i] >= 0 && gcnt[i] - 2 == drop_at[i]);
      end else if (gcnt[i] > 0) begin
        gcnt[i] = 0;
        drop_at[i] = -1;
        if (bursts[i] > 0) bursts[i]--;
        r = 1'b0;
      end else if (noise[i]) r = bus.grant[0] ? 1'($urandom) : 1'b0;
      else if (rnd[i]) r = bus.req[i] || ($urandom % 4 == 0);
      else r = bursts[i] > 0;
      bus.req[i] = r;
      a = rnd[i] ? AW'($urandom) : AW'(base[i] + (gcnt[i] >= 2 ? gcnt[i] - 2 : 0));
      bus.addr_in[i*AW +: AW] = a;
      bus.data_in[i*DATA_WIDTH +: DATA_WIDTH] = rnd[i] ? 8'($urandom) : 8'hA0 + 8'(a);
    end
  endtask
  task automatic cycle();
    if (rst) model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    drive();
  endtask
  task automatic reset_dut();
    rst = 1'b0;
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) begin
      gcnt[i] = 0; bursts[i] = 0; drop_at[i] = -1; base[i] = 16 * i; rnd[i] = 0; noise[i] = 0;
    end
    m_own = -1; m_beats = 0; m_ptr = 0; m_first = 0; m_gap = 0; m_err = 0; m_we = 0;
    m_done = '0; m_addr = '0; m_din = '0;
    #1;
    check("rst_grant", bus.grant, 0);
    check("rst_we", bus.ram_we, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_addr", bus.ram_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    wr_cnt = 0; wr_hi = 0; g0_cycles = 0; g1_cycles = 0; prev_grant = '0;
    order.delete();
  endtask
  initial begin
    bus.req = '0;
    bus.addr_in = '0;
    bus.data_in = '0;
    reset_dut();
    bursts[0] = 1;
    drive();
    repeat (30) cycle();
    check("t1_writes", wr_cnt, 16);
    check("t1_grant_cycles", g0_cycles, 17);
    check("t1_done", bus.done, 2'b01);
    check("t1_err", bus.err, 0);
    reset_dut();
    bursts[0] = 1; bursts[1] = 1;
    drive();
    repeat (50) cycle();
    check("t2_writes", wr_cnt, 32);
    check("t2_done", bus.done, 2'b11);
    check("t2_grants", order.size(), 2);
    if (order.size() == 2) begin
      check("t2_first", order[0], 2'b01);
      check("t2_second", order[1], 2'b10);
    end
    reset_dut();
    bursts[0] = 2; bursts[1] = 1;
    drive();
    repeat (80) cycle();
    check("t3_grants", order.size(), 3);
    if (order.size() == 3) begin
      check("t3_order0", order[0], 2'b01);
      check("t3_order1", order[1], 2'b10);
      check("t3_order2", order[2], 2'b01);
    end
    check("t3_writes", wr_cnt, 48);
    reset_dut();
    bursts[0] = 1; bursts[1] = 1; drop_at[0] = 5;
    drive();
    repeat (50) cycle();
    check("t4_writes", wr_cnt, 21);
    check("t4_err", bus.err, 1);
    check("t4_done", bus.done, 2'b10);
    reset_dut();
    bursts[0] = 1;
    drive();
    for (int k = 0; k < 40 && wr_cnt < 8; k++) cycle();
    check("t5_beats", wr_cnt, 8);
    reset_dut();
    bursts[1] = 1;
    drive();
    cycle();
    check("t5_grant", bus.grant, 2'b10);
    repeat (25) cycle();
    check("t5_done", bus.done, 2'b10);
    reset_dut();
    bursts[0] = 1; noise[1] = 1;
    drive();
    repeat (30) cycle();
    check("t6_writes", wr_cnt, 16);
    check("t6_foreign_addr", wr_hi, 0);
    check("t6_ch1_grant", g1_cycles, 0);
    check("t6_done", bus.done, 2'b01);
    for (int r = 0; r < 3; r++) begin
      reset_dut();
      rnd[0] = 1; rnd[1] = 1;
      drive();
      repeat (300) cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
